tube_gate_readout: RTL

//  Gate controller and readout sequencer for the array of tube hit-time capture cells.
//  - On a scintillator trigger it opens a fixed-length gate and drives the shared

---
 rtl/tube_gate_readout.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tube_gate_readout.sv
// ----------------------------------------------------------------------------
// tube_gate_readout
//
// Gate controller and readout sequencer for the tube hit-time capture cells.
//
// On a trigger it opens a fixed-length gate and drives a shared time counter
// into every cell. It then streams each cell's captured value out on a
// valid/ready interface. Finally it pulses the cells' clear line and re-arms.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   clr_n      : asynchronous active-low reset
//   trig       : trigger (synchronous to clk), accepted only while idle
//   tube_data  : captured counter values, tube 0 in the LSBs
//   gate_en    : gate enable to all cells, high only while gating
//   tube_cntr  : shared time counter to all cells
//   tube_clr   : active-high clear to all cells
//   busy       : high whenever the sequencer is not idle
//   out_valid  : readout word valid
//   out_ready  : downstream accepts when out_valid & out_ready
//   out_tube   : tube index of the current word
//   out_time   : captured value of tube out_tube
//   out_hit    : tube fired inside the gate (value differs from GATE_LEN)
//   out_last   : word belongs to the last tube
//   evt_count  : accepted triggers, wrapping
//   drop_count : triggers seen while busy, saturating
//
// N_TUBES must be at least 2.
// ----------------------------------------------------------------------------
module tube_gate_readout #(
   parameter int N_TUBES  = 16,
   parameter int CNT_W    = 8,
   parameter int GATE_LEN = 200,
   parameter int CLR_LEN  = 2
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       trig,
   input  logic [N_TUBES*CNT_W-1:0]   tube_data,
   output logic                       gate_en,
   output logic [CNT_W-1:0]           tube_cntr,
   output logic                       tube_clr,
   output logic                       busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(N_TUBES)-1:0] out_tube,
   output logic [CNT_W-1:0]           out_time,
   output logic                       out_hit,
   output logic                       out_last,
   output logic [15:0]                evt_count,
   output logic [7:0]                 drop_count
);

   localparam int IDX_W = $clog2(N_TUBES);
   localparam int CLR_W = $clog2(CLR_LEN + 1);

   localparam logic [CNT_W-1:0] GATE_END = CNT_W'(GATE_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TUBES - 1);
   localparam logic [CLR_W-1:0] CLR_INIT = CLR_W'(CLR_LEN);

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_GATE   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_READ   = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [CLR_W-1:0]  clr_cnt_r;
   logic [CLR_W-1:0]  clr_cnt_nx_s;
   logic [CNT_W-1:0]  cntr_nx_s;
   logic [IDX_W-1:0]  idx_nx_s;
   logic              load_s;
   logic              accept_s;
   logic [CNT_W-1:0]  sel_time_s;

   // out_tube doubles as the readout index register.
   assign accept_s   = out_valid & out_ready;
   assign sel_time_s = tube_data[int'(idx_nx_s)*CNT_W +: CNT_W];

   // Next-state, next-counter and next-index logic.
   always_comb begin
      state_nx_s   = state_r;
      clr_cnt_nx_s = clr_cnt_r;
      cntr_nx_s    = tube_cntr;
      idx_nx_s     = out_tube;
      load_s       = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            cntr_nx_s = {CNT_W{1'b0}};
            if (clr_cnt_r <= CLR_W'(1)) begin
               state_nx_s = ST_IDLE;
            end else begin
               clr_cnt_nx_s = clr_cnt_r - CLR_W'(1);
            end
         end
         ST_IDLE: begin
            cntr_nx_s = {CNT_W{1'b0}};
            if (trig) begin
               state_nx_s = ST_GATE;
               cntr_nx_s  = CNT_W'(1);
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_GATE: begin
            if (tube_cntr == GATE_END) begin
               // Counter holds GATE_LEN so cells that never fired stay stable.
               state_nx_s = ST_SETTLE;
            end else begin
               cntr_nx_s = tube_cntr + CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            state_nx_s = ST_READ;
            idx_nx_s   = {IDX_W{1'b0}};
            load_s     = 1'b1;
         end
         ST_READ: begin
            if (accept_s) begin
               if (out_tube == LAST_IDX) begin
                  state_nx_s   = ST_CLEAR;
                  clr_cnt_nx_s = CLR_INIT;
                  cntr_nx_s    = {CNT_W{1'b0}};
               end else begin
                  idx_nx_s = out_tube + IDX_W'(1);
                  load_s   = 1'b1;
               end
            end else begin
               state_nx_s = ST_READ;
            end
         end
         default: begin
            state_nx_s   = ST_CLEAR;
            clr_cnt_nx_s = CLR_INIT;
            cntr_nx_s    = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and clear-length counter registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r   <= ST_CLEAR;
         clr_cnt_r <= CLR_INIT;
      end else begin
         state_r   <= state_nx_s;
         clr_cnt_r <= clr_cnt_nx_s;
      end
   end

   // Registered control and readout outputs, decoded from the next state.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         gate_en   <= 1'b0;
         tube_cntr <= {CNT_W{1'b0}};
         tube_clr  <= 1'b1;
         busy      <= 1'b1;
         out_valid <= 1'b0;
         out_tube  <= {IDX_W{1'b0}};
         out_time  <= {CNT_W{1'b0}};
         out_hit   <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         gate_en   <= (state_nx_s == ST_GATE);
         tube_cntr <= cntr_nx_s;
         tube_clr  <= (state_nx_s == ST_CLEAR);
         busy      <= (state_nx_s != ST_IDLE);
         out_valid <= (state_nx_s == ST_READ);
         // Word fields only change when a new word is presented, so they
         // stay stable while the consumer stalls.
         if (load_s) begin
            out_tube <= idx_nx_s;
            out_time <= sel_time_s;
            out_hit  <= (sel_time_s != GATE_END);
            out_last <= (idx_nx_s == LAST_IDX);
         end
      end
   end

   // Event and dropped-trigger statistics.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         evt_count  <= 16'd0;
         drop_count <= 8'd0;
      end else begin
         if (trig && (state_r == ST_IDLE)) begin
            evt_count <= evt_count + 16'd1;
         end
         if (trig && (state_r != ST_IDLE) && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule
